// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and defaults for the APB register bank: FSM states, bus widths, counter sizing.
package apb_slave_regbank_pkg;

   localparam int unsigned ApbAddrW = 4;
   localparam int unsigned ApbDataW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } apb_state_e;

   // Width needed to hold 0..max_val, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 completer-side bus bundle with master (bridge) and slave (register bank) views.
interface apb_slave_regbank_if #(
   parameter int unsigned AddrW = 4,
   parameter int unsigned DataW = 8
) ();

   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [AddrW-1:0] paddr;
   logic [DataW-1:0] pwdata;
   logic [DataW-1:0] prdata;
   logic             pready;
   logic             pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_slave_regbank_wait_counter.sv
// Wait-state counter: load on entry to the access phase, count down, flag zero.
// Compiled only when APB_WAIT_EN is defined, since nothing instantiates it otherwise.
`ifdef APB_WAIT_EN
module apb_slave_regbank_wait_counter
   import apb_slave_regbank_pkg::*;
#(
   parameter int unsigned MaxCount = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int unsigned CntW = cnt_width(MaxCount);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CntW'(MaxCount);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/apb_slave_regbank.sv
// APB3 completer register bank; register 0 mirrors to ctrl_o, top address reads status_i.
// Define APB_WAIT_EN to insert WaitCycles wait states per access.
module apb_slave_regbank
   import apb_slave_regbank_pkg::*;
#(
   parameter int unsigned AddrW      = ApbAddrW,
   parameter int unsigned DataW      = ApbDataW,
   parameter int unsigned NumRegs    = 15,
   parameter int unsigned WaitCycles = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   apb_slave_regbank_if.slave  apb_io,
   input  logic [DataW-1:0]    status_i,
   output logic [DataW-1:0]    ctrl_o
);

   localparam logic [AddrW-1:0] StatusAddr = '1;

   apb_state_e       state_d, state_q;
   logic [DataW-1:0] regs_q [NumRegs];
   logic [DataW-1:0] rd_data;
   logic             cnt_zero;
   logic             is_reg;
   logic             is_status;
   logic             dec_err;
   logic             ready;
   logic             wr_en;

`ifdef APB_WAIT_EN
   apb_slave_regbank_wait_counter #(
      .MaxCount(WaitCycles)
   ) u_wait_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load_i(state_q == StSetup && apb_io.psel && apb_io.penable),
      .dec_i (state_q == StAccess),
      .zero_o(cnt_zero)
   );
`else
   logic unused_wait_cycles;
   assign unused_wait_cycles = ^WaitCycles;
   assign cnt_zero           = 1'b1;
`endif

   assign is_reg    = 32'(apb_io.paddr) < NumRegs;
   assign is_status = (apb_io.paddr == StatusAddr);
   // Unmapped addresses always error; the status location errors only on writes.
   assign dec_err   = !is_reg && (apb_io.pwrite || !is_status);
   assign ready     = (state_q == StAccess) && apb_io.psel && cnt_zero;
   assign wr_en     = ready && apb_io.pwrite && is_reg;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (apb_io.psel && !apb_io.penable) state_d = StSetup;
         end
         StSetup: begin
            if (!apb_io.psel) begin
               state_d = StIdle;
            end else if (apb_io.penable) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (!apb_io.psel || ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < NumRegs; i++) begin
            if (32'(apb_io.paddr) == i) regs_q[i] <= apb_io.pwdata;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
         if (32'(apb_io.paddr) == i) rd_data = regs_q[i];
      end
      if (is_status) rd_data = status_i;
   end

   assign apb_io.pready  = ready;
   assign apb_io.pslverr = ready && dec_err;
   assign apb_io.prdata  = (ready && !apb_io.pwrite && !dec_err) ? rd_data : '0;
   assign ctrl_o         = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized APB bench for apb_slave_regbank with an array-based register model.
module tb_apb_slave_regbank;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned NR = 12;
   localparam int unsigned WC = 2;
`ifdef APB_WAIT_EN
   localparam int W = 2;
`else
   localparam int W = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] status_i;
   logic [DW-1:0] ctrl_o;

   always #5 clk = ~clk;

   apb_slave_regbank_if #(.AddrW(AW), .DataW(DW)) apb ();

   apb_slave_regbank #(
      .AddrW     (AW),
      .DataW     (DW),
      .NumRegs   (NR),
      .WaitCycles(WC)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .apb_io  (apb),
      .status_i(status_i),
      .ctrl_o  (ctrl_o)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] model_q [NR];
   bit            chk_en   = 1'b0;
   logic          exp_pready  = 1'b0;
   logic          exp_pslverr = 1'b0;
   logic [DW-1:0] exp_prdata  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pready", 32'(apb.pready), 32'(exp_pready));
         check("pslverr", 32'(apb.pslverr), 32'(exp_pslverr));
         check("prdata", 32'(apb.prdata), 32'(exp_prdata));
         check("ctrl_o", 32'(ctrl_o), 32'(model_q[0]));
      end
   end

   task automatic clear_model();
      for (int i = 0; i < int'(NR); i++) model_q[i] = '0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // mode 0: normal transfer, 1: psel dropped in final access cycle, 2: reset in final access cycle.
   // lat is the number of cycles from penable rising to pready, -1 if never seen.
   task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input int mode, output logic [DW-1:0] rd, output bit err_o,
                       output int lat);
      int            ai;
      bit            err;
      bit            fin;
      logic [DW-1:0] rexp;
      ai   = int'(addr);
      err  = (ai >= int'(NR)) && (wr || ai != (1 << AW) - 1);
      rexp = (ai < int'(NR)) ? model_q[ai] : status_i;
      rd   = '0;
      err_o = 1'b0;
      lat  = -1;
      apb.psel    = 1'b1;
      apb.penable = 1'b0;
      apb.pwrite  = wr;
      apb.paddr   = addr;
      apb.pwdata  = data;
      @(posedge clk);
      #1;
      apb.penable = 1'b1;
      for (int k = 0; k <= W + 1; k++) begin
         fin = (k == W + 1);
         if (fin && mode == 1) apb.psel = 1'b0;
         if (fin && mode == 2) begin
            rst    = 1'b1;
            chk_en = 1'b0;
         end
         exp_pready  = fin && (mode == 0);
         exp_pslverr = exp_pready && err;
         exp_prdata  = (exp_pready && !wr && !err) ? rexp : '0;
         #1;
         if (apb.pready && lat < 0) begin
            lat   = k;
            rd    = apb.prdata;
            err_o = apb.pslverr;
         end
         @(posedge clk);
         #1;
         if (fin && mode == 0 && wr && ai < int'(NR)) model_q[ai] = data;
         if (fin && mode == 2) clear_model();
      end
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      exp_pready  = 1'b0;
      exp_pslverr = 1'b0;
      exp_prdata  = '0;
      rst         = 1'b0;
      chk_en      = 1'b1;
   endtask

   logic [DW-1:0] rd;
   bit            err;
   int            lat;

   initial begin
      rst         = 1'b1;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      apb.pwrite  = 1'b0;
      apb.paddr   = '0;
      apb.pwdata  = '0;
      status_i    = '0;
      clear_model();

      // Two reset cycles, outputs all zero.
      idle();
      chk_en = 1'b1;
      idle();
      check("rst_pready", 32'(apb.pready), 32'h0);
      check("rst_pslverr", 32'(apb.pslverr), 32'h0);
      check("rst_prdata", 32'(apb.prdata), 32'h0);
      check("rst_ctrl", 32'(ctrl_o), 32'h0);
      rst = 1'b0;
      idle();

      // Write then read register 0.
      xfer(1'b1, 4'd0, 8'hA5, 0, rd, err, lat);
      check("wr0_lat", 32'(lat), 32'(W + 1));
      check("wr0_ctrl", 32'(ctrl_o), 32'hA5);
      xfer(1'b0, 4'd0, 8'h00, 0, rd, err, lat);
      check("rd0_data", 32'(rd), 32'hA5);

      // Read latency on a plain register.
      idle();
      xfer(1'b0, 4'd3, 8'h00, 0, rd, err, lat);
      check("rd3_lat", 32'(lat), 32'(W + 1));
      check("rd3_data", 32'(rd), 32'h0);

      // Status location: write errors, read returns status_i.
      status_i = 8'h3C;
      xfer(1'b1, 4'd15, 8'hEE, 0, rd, err, lat);
      check("wr15_err", 32'(err), 32'h1);
      xfer(1'b0, 4'd15, 8'h00, 0, rd, err, lat);
      check("rd15_data", 32'(rd), 32'h3C);
      check("rd15_err", 32'(err), 32'h0);

      // Unmapped address errors on read and write.
      xfer(1'b0, 4'd13, 8'h00, 0, rd, err, lat);
      check("rd13_err", 32'(err), 32'h1);
      check("rd13_data", 32'(rd), 32'h0);
      xfer(1'b1, 4'd12, 8'h5A, 0, rd, err, lat);
      check("wr12_err", 32'(err), 32'h1);

      // Back-to-back writes with no idle cycle between them.
      xfer(1'b1, 4'd1, 8'h11, 0, rd, err, lat);
      xfer(1'b1, 4'd2, 8'h22, 0, rd, err, lat);
      xfer(1'b0, 4'd1, 8'h00, 0, rd, err, lat);
      check("b2b_rd1", 32'(rd), 32'h11);
      xfer(1'b0, 4'd2, 8'h00, 0, rd, err, lat);
      check("b2b_rd2", 32'(rd), 32'h22);

      // psel abandoned before completion: no write.
      xfer(1'b1, 4'd5, 8'h99, 1, rd, err, lat);
      check("abort_lat", 32'(lat), 32'hFFFF_FFFF);
      xfer(1'b0, 4'd5, 8'h00, 0, rd, err, lat);
      check("abort_rd5", 32'(rd), 32'h0);

      // psel+penable without a setup phase gets no response.
      apb.psel    = 1'b1;
      apb.penable = 1'b1;
      apb.pwrite  = 1'b1;
      apb.paddr   = 4'd6;
      apb.pwdata  = 8'h66;
      repeat (3) idle();
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      idle();
      xfer(1'b0, 4'd6, 8'h00, 0, rd, err, lat);
      check("nosetup_rd6", 32'(rd), 32'h0);

      // Reset during the final access cycle of a write.
      xfer(1'b1, 4'd4, 8'h5A, 0, rd, err, lat);
      xfer(1'b1, 4'd4, 8'h77, 2, rd, err, lat);
      check("rstmid_ctrl", 32'(ctrl_o), 32'h0);
      check("rstmid_pready", 32'(apb.pready), 32'h0);
      xfer(1'b0, 4'd4, 8'h00, 0, rd, err, lat);
      check("rstmid_rd4", 32'(rd), 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 250; n++) begin
         int mode;
         mode     = ($urandom_range(0, 9) == 0) ? 1 : 0;
         status_i = DW'($urandom);
         xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), mode,
              rd, err, lat);
         repeat ($urandom_range(0, 2)) idle();
      end

      idle();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
